wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage between the memory stage and register_file. It captures one retiring instruction per handshake and waits for variable-latency data-memory read data on loads. It aligns and sign/zero-extends load data, selects the writeback source, and drives the register file write port (rd, rd_value, register_write). It also provides a forwarding tap and a 32-bit retired-instruction counter.

Parameters:
XLEN, 32, datapath width
INSTRET_W, 32, width of the retire counter (wraps)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous active-high reset
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can accept this cycle
in_rd  input  5  destination register
in_wb_en  input  1  instruction writes a GPR
in_wb_sel  input  2  0=ALU, 1=LOAD, 2=LINK, 3=CSR
in_alu_result  input  XLEN  ALU result; for loads, the byte address
in_link  input  XLEN  link value from upstream
in_csr_data  input  XLEN  csr_read_data from register_file
in_funct3  input  3  load type: 0=LB 1=LH 2=LW 4=LBU 5=LHU
dmem_rvalid  input  1  load data valid (one-cycle pulse)
dmem_rdata  input  XLEN  raw aligned word from data memory
rd  output  5  to register_file.rd
rd_value  output  XLEN  to register_file.rd_value
register_write  output  1  to register_file.register_write
fwd_valid  output  1  rd/rd_value hold a result being written this cycle
load_misaligned  output  1  one-cycle pulse: faulting load retired without a write
instret  output  INSTRET_W  retired instruction count

Behaviour:
- Reset (sync, rst high at posedge) values:
  - state=IDLE; rd=0, rd_value=0.
  - register_write=0, fwd_valid=0, load_misaligned=0.
  - instret=0; in_ready=1 in the cycle after reset.
- FSM states: IDLE, WAIT_LOAD, WRITE.
- in_ready=1 in IDLE and WRITE; in_ready=0 in WAIT_LOAD.
- Accept: in_valid && in_ready at posedge captures all in_* fields.
  - Non-load (wb_sel!=1): go to WRITE. Outputs are driven in the next cycle (latency 1).
  - Aligned load: go to WAIT_LOAD.
  - Misaligned load: go to WRITE with write suppressed and load_misaligned pulsed.
    - Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
    - funct3 of 3, 6 or 7 is also treated as misaligned.
- WAIT_LOAD: on dmem_rvalid, align dmem_rdata and go to WRITE.
  - Alignment: byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - dmem_rvalid in IDLE or WRITE with no load pending is ignored.
- WRITE (exactly one cycle per instruction):
  - register_write = wb_en && rd!=0 && !misaligned.
  - fwd_valid = register_write.
  - instret increments by 1 (including faulting loads); wraps from all-ones to 0.
  - Next state: if a new accept occurs in the same cycle, go to WRITE or WAIT_LOAD per the new instruction (back-to-back, one per cycle); otherwise go to IDLE.
- Outside WRITE: register_write=0, fwd_valid=0. rd and rd_value hold their last values.
- rd==0 with wb_en=1: no write and no forward, but the instruction still retires.
- rst asserted in WAIT_LOAD: the pending load is dropped and a late dmem_rvalid after reset is ignored.
- Source mux in the capture cycle: ALU→alu_result, LINK→in_link, CSR→in_csr_data.
- No combinational path from in_* to outputs; outputs are registered.

Decomposition:
- Shared package (cpu_pkg) holds:
  - WB_SEL_ALU/LOAD/LINK/CSR encodings
  - LOAD_LB/LH/LW/LBU/LHU funct3 constants
  - FSM state encodings
- One sub-module is natural: load_align, a combinational unit mapping (funct3, addr[1:0], rdata) to (value, misaligned). It is reusable by a future store path checker.

Test Plan:
- ALU op rd=5, alu_result=0x0000_1234, accepted at cycle N → register_write=1, rd=5, rd_value=0x1234 at cycle N+1; instret 0→1.
- LB addr=...03, dmem_rdata=0x80FF_0000 arriving 3 cycles later → in_ready=0 while waiting; next cycle rd_value=0xFFFF_FF80; LBU same case → 0x0000_0080.
- LH addr=...01 → no write, load_misaligned pulse for one cycle, instret increments, no dmem wait.
- Back-to-back accepts: ALU, CSR (csr_data=0), LINK (link=0x104) on three consecutive cycles → three consecutive register_write pulses with values 0x?, 0x0, 0x104; in_ready stays 1.
- rd=0 with wb_en=1 → register_write=0, fwd_valid=0, instret increments; instret preset path reaches 0xFFFF_FFFF then wraps to 0 on the next retire.
- rst during WAIT_LOAD, then dmem_rvalid one cycle after reset → no write, state IDLE, instret=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the writeback stage: writeback source select,
// load funct3 types and the writeback FSM states.
package cpu_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;
  localparam logic [1:0] WB_SEL_CSR  = 2'd3;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LW  = 3'd2;
  localparam logic [2:0] LOAD_LBU = 3'd4;
  localparam logic [2:0] LOAD_LHU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_WRITE     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the byte/halfword lane from a raw word,
// sign/zero-extends it and flags misaligned or unsupported load types.
module load_align
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] value,
  output logic            misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

    value      = '0;
    misaligned = 1'b0;
    case (funct3)
      LOAD_LB:  value = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LOAD_LBU: value = {{(XLEN-8){1'b0}}, byte_lane};
      LOAD_LH: begin
        value      = {{(XLEN-16){half_lane[15]}}, half_lane};
        misaligned = addr[0];
      end
      LOAD_LHU: begin
        value      = {{(XLEN-16){1'b0}}, half_lane};
        misaligned = addr[0];
      end
      LOAD_LW: begin
        value      = rdata;
        misaligned = (addr != 2'b00);
      end
      // funct3 3, 6 and 7 are not legal loads; they retire as faults.
      default:  misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: captures one retiring instruction per handshake, waits for
// load data when needed and drives the register-file write port for one cycle.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rd,
  input  logic                 in_wb_en,
  input  logic [1:0]           in_wb_sel,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_link,
  input  logic [XLEN-1:0]      in_csr_data,
  input  logic [2:0]           in_funct3,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic [4:0]           rd,
  output logic [XLEN-1:0]      rd_value,
  output logic                 register_write,
  output logic                 fwd_valid,
  output logic                 load_misaligned,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  wb_state_e              state_reg, state_next;
  logic [4:0]             rd_reg, rd_next;
  logic [XLEN-1:0]        rd_value_reg, rd_value_next;
  logic                   write_reg, write_next;
  logic                   misaligned_reg, misaligned_next;
  logic [INSTRET_W-1:0]   instret_reg, instret_next;
  logic [4:0]             pend_rd_reg;
  logic                   pend_wb_en_reg;
  logic [2:0]             pend_funct3_reg;
  logic [1:0]             pend_addr_reg;

  logic                   accept;
  logic                   waiting;
  logic [2:0]             align_funct3;
  logic [1:0]             align_addr;
  logic [XLEN-1:0]        align_value;
  logic                   align_misaligned;
  logic [XLEN-1:0]        src_value;

  assign waiting  = (state_reg == ST_WAIT_LOAD);
  assign in_ready = !waiting;
  assign accept   = in_valid && in_ready;

  // The aligner checks the incoming instruction while ready and the pending
  // load while waiting; each result is only consumed in its own state.
  assign align_funct3 = waiting ? pend_funct3_reg : in_funct3;
  assign align_addr   = waiting ? pend_addr_reg   : in_alu_result[1:0];

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3     (align_funct3),
    .addr       (align_addr),
    .rdata      (dmem_rdata),
    .value      (align_value),
    .misaligned (align_misaligned)
  );

  always_comb begin
    case (in_wb_sel)
      WB_SEL_LINK: src_value = in_link;
      WB_SEL_CSR:  src_value = in_csr_data;
      default:     src_value = in_alu_result;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    rd_next         = rd_reg;
    rd_value_next   = rd_value_reg;
    write_next      = 1'b0;
    misaligned_next = 1'b0;
    instret_next    = instret_reg;
    case (state_reg)
      ST_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_next    = ST_WRITE;
          rd_next       = pend_rd_reg;
          rd_value_next = align_value;
          write_next    = pend_wb_en_reg && (pend_rd_reg != 5'd0);
          instret_next  = instret_reg + INSTRET_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        if (accept) begin
          if (in_wb_sel != WB_SEL_LOAD) begin
            state_next    = ST_WRITE;
            rd_next       = in_rd;
            rd_value_next = src_value;
            write_next    = in_wb_en && (in_rd != 5'd0);
            instret_next  = instret_reg + INSTRET_ONE;
          end else if (align_misaligned) begin
            state_next      = ST_WRITE;
            misaligned_next = 1'b1;
            instret_next    = instret_reg + INSTRET_ONE;
          end else begin
            state_next = ST_WAIT_LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      rd_reg         <= 5'd0;
      rd_value_reg   <= '0;
      write_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      instret_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      rd_reg         <= rd_next;
      rd_value_reg   <= rd_value_next;
      write_reg      <= write_next;
      misaligned_reg <= misaligned_next;
      instret_reg    <= instret_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rd_reg     <= 5'd0;
      pend_wb_en_reg  <= 1'b0;
      pend_funct3_reg <= 3'd0;
      pend_addr_reg   <= 2'd0;
    end else if (accept) begin
      pend_rd_reg     <= in_rd;
      pend_wb_en_reg  <= in_wb_en;
      pend_funct3_reg <= in_funct3;
      pend_addr_reg   <= in_alu_result[1:0];
    end
  end

  assign rd              = rd_reg;
  assign rd_value        = rd_value_reg;
  assign register_write  = write_reg;
  assign fwd_valid       = write_reg;
  assign load_misaligned = misaligned_reg;
  assign instret         = instret_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized checks of wb_stage against a behavioural model of
// load alignment, writeback selection and retire counting.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_link;
  logic [31:0] in_csr_data;
  logic [2:0]  in_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic        register_write;
  logic        fwd_valid;
  logic        load_misaligned;
  logic [31:0] instret;

  logic        s_in_ready;
  logic [4:0]  s_rd;
  logic [31:0] s_rd_value;
  logic        s_register_write;
  logic        s_fwd_valid;
  logic        s_load_misaligned;
  logic [3:0]  s_instret;

  int tests = 0;
  int fails = 0;
  int retired = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wb_en(in_wb_en), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_link(in_link), .in_csr_data(in_csr_data),
    .in_funct3(in_funct3), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd(rd), .rd_value(rd_value), .register_write(register_write),
    .fwd_valid(fwd_valid), .load_misaligned(load_misaligned), .instret(instret)
  );

  // Narrow counter copy so the wrap from all-ones to zero is reachable.
  wb_stage #(.XLEN(32), .INSTRET_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rd(in_rd), .in_wb_en(in_wb_en), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_link(in_link), .in_csr_data(in_csr_data),
    .in_funct3(in_funct3), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd(s_rd), .rd_value(s_rd_value), .register_write(s_register_write),
    .fwd_valid(s_fwd_valid), .load_misaligned(s_load_misaligned), .instret(s_instret)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    return 1'b1;
    endcase
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    longint v;
    longint w;
    w = longint'(word);
    case (f3)
      3'd0, 3'd4: begin
        v = (w / (longint'(1) << (8 * (addr % 4)))) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w / (longint'(1) << (16 * ((addr / 2) % 2)))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_rd         = 5'd0;
    in_wb_en      = 1'b0;
    in_wb_sel     = 2'd0;
    in_alu_result = 32'd0;
    in_link       = 32'd0;
    in_csr_data   = 32'd0;
    in_funct3     = 3'd0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = 32'd0;
  endtask

  // Issues one instruction in isolation, supplies load data after lat cycles
  // and checks the write cycle plus the idle cycle that follows it.
  task automatic issue(input string name, input logic [4:0] r, input logic en,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] link,
                       input logic [31:0] csr, input logic [2:0] f3, input logic [31:0] word,
                       input int lat);
    bit          mis;
    logic [31:0] exp_val;
    bit          exp_wr;
    in_valid = 1'b1; in_rd = r; in_wb_en = en; in_wb_sel = sel;
    in_alu_result = alu; in_link = link; in_csr_data = csr; in_funct3 = f3;
    mis = (sel == 2'd1) && model_misaligned(f3, alu);
    case (sel)
      2'd1:    exp_val = model_load(f3, alu, word);
      2'd2:    exp_val = link;
      2'd3:    exp_val = csr;
      default: exp_val = alu;
    endcase
    exp_wr = en && (r != 5'd0) && !mis;
    step();
    idle_inputs();
    if (sel == 2'd1 && !mis) begin
      for (int i = 0; i < lat; i++) begin
        check({name, " in_ready_wait"}, 32'(in_ready), 32'd0);
        step();
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = word;
      step();
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'd0;
    end
    retired++;
    $display("[TB] %s rd=%0d sel=%0d f3=%0d addr=0x%08h exp_wr=%0d exp_val=0x%08h mis=%0d",
             name, r, sel, f3, alu, exp_wr, exp_val, mis);
    check({name, " register_write"}, 32'(register_write), 32'(exp_wr));
    check({name, " fwd_valid"}, 32'(fwd_valid), 32'(exp_wr));
    check({name, " load_misaligned"}, 32'(load_misaligned), 32'(mis));
    if (exp_wr) begin
      check({name, " rd"}, 32'(rd), 32'(r));
      check({name, " rd_value"}, rd_value, exp_val);
    end
    step();
    check({name, " write_drop"}, 32'(register_write), 32'd0);
    check({name, " misaligned_drop"}, 32'(load_misaligned), 32'd0);
    check({name, " instret"}, instret, 32'(retired));
    check({name, " instret_small"}, 32'(s_instret), 32'(retired % 16));
    check({name, " in_ready_idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    retired = 0;
  endtask

  initial begin
    do_reset();
    check("reset rd", 32'(rd), 32'd0);
    check("reset rd_value", rd_value, 32'd0);
    check("reset register_write", 32'(register_write), 32'd0);
    check("reset fwd_valid", 32'(fwd_valid), 32'd0);
    check("reset load_misaligned", 32'(load_misaligned), 32'd0);
    check("reset instret", instret, 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    issue("alu",      5'd5, 1'b1, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 3'd0, 32'd0, 0);
    issue("lb",       5'd7, 1'b1, 2'd1, 32'h0000_1003, 32'd0, 32'd0, 3'd0, 32'h80FF_0000, 3);
    check("lb value", rd_value, 32'hFFFF_FF80);
    issue("lbu",      5'd8, 1'b1, 2'd1, 32'h0000_1003, 32'd0, 32'd0, 3'd4, 32'h80FF_0000, 3);
    check("lbu value", rd_value, 32'h0000_0080);
    issue("lh_mis",   5'd9, 1'b1, 2'd1, 32'h0000_2001, 32'd0, 32'd0, 3'd1, 32'hDEAD_BEEF, 0);
    issue("lw_mis",   5'd9, 1'b1, 2'd1, 32'h0000_2002, 32'd0, 32'd0, 3'd2, 32'hDEAD_BEEF, 0);
    issue("f3_bad",   5'd9, 1'b1, 2'd1, 32'h0000_2000, 32'd0, 32'd0, 3'd3, 32'hDEAD_BEEF, 0);
    issue("lhu_hi",   5'd10, 1'b1, 2'd1, 32'h0000_3002, 32'd0, 32'd0, 3'd5, 32'h9ABC_1234, 1);
    issue("lh_hi",    5'd11, 1'b1, 2'd1, 32'h0000_3002, 32'd0, 32'd0, 3'd1, 32'h9ABC_1234, 0);
    issue("lw",       5'd12, 1'b1, 2'd1, 32'h0000_3004, 32'd0, 32'd0, 3'd2, 32'hCAFE_F00D, 2);
    issue("rd0",      5'd0, 1'b1, 2'd0, 32'h5555_AAAA, 32'd0, 32'd0, 3'd0, 32'd0, 0);
    issue("no_wb_en", 5'd3, 1'b0, 2'd2, 32'd0, 32'h0000_0200, 32'd0, 3'd0, 32'd0, 0);

    // Back-to-back ALU, CSR and LINK on consecutive cycles.
    in_valid = 1'b1; in_wb_en = 1'b1; in_funct3 = 3'd0;
    in_rd = 5'd1; in_wb_sel = 2'd0; in_alu_result = 32'h0000_0ABC;
    step();
    check("b2b alu write", 32'(register_write), 32'd1);
    check("b2b alu value", rd_value, 32'h0000_0ABC);
    check("b2b ready0", 32'(in_ready), 32'd1);
    in_rd = 5'd2; in_wb_sel = 2'd3; in_csr_data = 32'd0; in_alu_result = 32'h1111_1111;
    step();
    check("b2b csr write", 32'(register_write), 32'd1);
    check("b2b csr rd", 32'(rd), 32'd2);
    check("b2b csr value", rd_value, 32'd0);
    check("b2b ready1", 32'(in_ready), 32'd1);
    in_rd = 5'd31; in_wb_sel = 2'd2; in_link = 32'h0000_0104;
    step();
    idle_inputs();
    check("b2b link write", 32'(register_write), 32'd1);
    check("b2b link rd", 32'(rd), 32'd31);
    check("b2b link value", rd_value, 32'h0000_0104);
    retired += 3;
    step();
    check("b2b drop", 32'(register_write), 32'd0);
    check("b2b instret", instret, 32'(retired));
    $display("[TB] back-to-back alu/csr/link retired=%0d", retired);

    for (int n = 0; n < 24; n++) begin
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [31:0] addr;
      sel  = 2'($urandom_range(0, 3));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      issue($sformatf("rand%0d", n), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            sel, addr, $urandom, $urandom, f3, $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while a load waits; late data afterwards must be ignored.
    in_valid = 1'b1; in_rd = 5'd4; in_wb_en = 1'b1; in_wb_sel = 2'd1;
    in_funct3 = 3'd2; in_alu_result = 32'h0000_4000;
    step();
    idle_inputs();
    check("rst_wait in_ready", 32'(in_ready), 32'd0);
    step();
    do_reset();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    step();
    dmem_rvalid = 1'b0;
    check("rst_wait no write", 32'(register_write), 32'd0);
    check("rst_wait in_ready", 32'(in_ready), 32'd1);
    check("rst_wait instret", instret, 32'd0);
    step();
    check("rst_wait still idle", 32'(register_write), 32'd0);
    check("rst_wait instret2", instret, 32'd0);
    $display("[TB] reset during wait_load, late rvalid ignored");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
